// File: rtl/mod7_frame_serializer_pkg.sv
// Shared constants, FSM encoding and mod-7 arithmetic for the serial
// divisibility-by-7 link (serializer and checker).
package mod7_frame_serializer_pkg;

  localparam int MODULUS     = 7;
  localparam int CHECK_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // One MSB-first step of serial remainder tracking: (2*rem + bit) mod 7.
  // The doubled value never exceeds 13, so one conditional subtract suffices.
  function automatic logic [2:0] mod7_step_f(input logic [2:0] rem, input logic bit_in);
    logic [3:0] acc;
    logic [3:0] red;
    acc = {rem, 1'b0} + {3'b000, bit_in};
    red = acc - 4'(MODULUS);
    if (acc >= 4'(MODULUS)) begin
      return red[2:0];
    end else begin
      return acc[2:0];
    end
  endfunction

  // Check field that brings the frame remainder to zero; never 3'b111.
  function automatic logic [2:0] mod7_check_f(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 3'd0;
    end else begin
      return 3'(MODULUS) - rem;
    end
  endfunction

endpackage

// File: rtl/mod7_frame_serializer_if.sv
// Payload handshake and serial-line bundle between a payload source and the
// mod-7 frame serializer.
interface mod7_frame_serializer_if
  import mod7_frame_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0]  Data_In;
  logic                   Data_Valid;
  logic                   Data_Ready;
  logic                   String;
  logic                   Bit_Valid;
  logic                   Bit_Last;
  logic [CHECK_WIDTH-1:0] Check;

  modport master (
    output Data_In, Data_Valid,
    input  Data_Ready, String, Bit_Valid, Bit_Last, Check
  );

  modport slave (
    input  Data_In, Data_Valid,
    output Data_Ready, String, Bit_Valid, Bit_Last, Check
  );

endinterface

// File: rtl/mod7_frame_serializer_step.sv
// Combinational mod-7 remainder step, shared by the serializer and the
// downstream divisibility checker.
module mod7_step
  import mod7_frame_serializer_pkg::*;
(
  input  logic [2:0] rem_i,
  input  logic       bit_i,
  output logic [2:0] rem_o
);

  // Next remainder after appending one bit.
  always_comb begin
    rem_o = mod7_step_f(rem_i, bit_i);
  end

endmodule

// File: rtl/mod7_frame_serializer.sv
// Serializes a payload MSB-first followed by a 3-bit check field so that the
// whole frame, read as a binary number, is divisible by 7.
module mod7_frame_serializer
  import mod7_frame_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Tick,
  mod7_frame_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CHECK_WIDTH-1:0] chk_sh_q, chk_sh_d;
  logic [CHECK_WIDTH-1:0] check_q, check_d;
  logic [2:0]             rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             rem_next_s;
  logic [2:0]             check_next_s;

  mod7_step u_step (
    .rem_i (rem_q),
    .bit_i (shreg_q[DATA_WIDTH-1]),
    .rem_o (rem_next_s)
  );

  assign check_next_s = mod7_check_f(rem_next_s);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      chk_sh_q <= '0;
      check_q  <= '0;
      rem_q    <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      chk_sh_q <= chk_sh_d;
      check_q  <= check_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update; only acceptance ignores Tick.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    chk_sh_d = chk_sh_q;
    check_d  = check_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          shreg_d = bus.Data_In;
          rem_d   = 3'd0;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (Tick) begin
          rem_d   = rem_next_s;
          shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            chk_sh_d = check_next_s;
            check_d  = check_next_s;
            cnt_d    = CNT_W'(2);
            state_d  = ST_CHECK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (Tick) begin
          chk_sh_d = {chk_sh_q[CHECK_WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    bus.Data_Ready = 1'b0;
    bus.String     = 1'b0;
    bus.Bit_Valid  = 1'b0;
    bus.Bit_Last   = 1'b0;
    bus.Check      = check_q;
    case (state_q)
      ST_IDLE: begin
        bus.Data_Ready = 1'b1;
      end
      ST_DATA: begin
        bus.String    = shreg_q[DATA_WIDTH-1];
        bus.Bit_Valid = 1'b1;
      end
      ST_CHECK: begin
        bus.String    = chk_sh_q[CHECK_WIDTH-1];
        bus.Bit_Valid = 1'b1;
        if (cnt_q == '0) begin
          bus.Bit_Last = 1'b1;
        end else begin
          bus.Bit_Last = 1'b0;
        end
      end
      default: begin
        bus.Data_Ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mod7_frame_serializer.sv
// Directed self-checking bench for the mod-7 frame serializer (DATA_WIDTH=8).
module tb_mod7_frame_serializer;

  logic Clock;
  logic Reset;
  logic Tick;
  int   n_tests;
  int   n_fail;

  mod7_frame_serializer_if #(.DATA_WIDTH(8)) ifc ();

  mod7_frame_serializer #(.DATA_WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bus   (ifc.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Offers one payload and captures the frame; with div>1, Tick pulses every div cycles.
  task automatic send_frame(input logic [7:0] p, input int div,
                            output logic [10:0] seq, output logic [10:0] last_m,
                            output logic [10:0] valid_m, output int hold_err);
    hold_err = 0;
    seq = '0; last_m = '0; valid_m = '0;
    ifc.Data_In = p;
    ifc.Data_Valid = 1'b1;
    Tick = (div == 1);
    step();
    ifc.Data_Valid = 1'b0;
    for (int b = 0; b < 11; b++) begin
      for (int k = 0; k < div; k++) begin
        Tick = (k == div - 1);
        if (k == 0) begin
          seq[10-b]     = ifc.String;
          last_m[10-b]  = ifc.Bit_Last;
          valid_m[10-b] = ifc.Bit_Valid;
        end else if (ifc.String !== seq[10-b] || ifc.Bit_Valid !== 1'b1) begin
          hold_err++;
        end
        step();
      end
    end
    Tick = 1'b1;
  endtask

  logic [10:0] seq, last_m, valid_m;
  int          hold_err;
  logic [22:0] str_obs, val_obs, rdy_obs;
  logic [2:0]  c_exp;
  logic [10:0] frame_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset = 1'b0;
    Tick = 1'b1;
    ifc.Data_In = 8'd0;
    ifc.Data_Valid = 1'b0;
    step();
    step();
    check_eq("rst_ready", 32'(ifc.Data_Ready), 32'd1);
    check_eq("rst_valid", 32'(ifc.Bit_Valid), 32'd0);
    check_eq("rst_string", 32'(ifc.String), 32'd0);
    check_eq("rst_last", 32'(ifc.Bit_Last), 32'd0);
    check_eq("rst_check", 32'(ifc.Check), 32'd0);
    Reset = 1'b1;
    step();

    send_frame(8'd13, 1, seq, last_m, valid_m, hold_err);
    check_eq("p13_seq", 32'(seq), 32'(11'b0000_1101_001));
    check_eq("p13_check", 32'(ifc.Check), 32'd1);
    check_eq("p13_last", 32'(last_m), 32'd1);
    check_eq("p13_valid", 32'(valid_m), 32'h7FF);
    check_eq("p13_idle_valid", 32'(ifc.Bit_Valid), 32'd0);
    check_eq("p13_idle_ready", 32'(ifc.Data_Ready), 32'd1);

    send_frame(8'hFF, 1, seq, last_m, valid_m, hold_err);
    check_eq("pff_seq", 32'(seq), 32'(11'b1111_1111_100));
    check_eq("pff_check", 32'(ifc.Check), 32'd4);

    send_frame(8'd0, 1, seq, last_m, valid_m, hold_err);
    check_eq("p0_seq", 32'(seq), 32'd0);
    check_eq("p0_check", 32'(ifc.Check), 32'd0);
    check_eq("p0_valid", 32'(valid_m), 32'h7FF);

    send_frame(8'd100, 3, seq, last_m, valid_m, hold_err);
    check_eq("tick3_seq", 32'(seq), 32'(11'b0110_0100_101));
    check_eq("tick3_hold", 32'(hold_err), 32'd0);
    check_eq("tick3_last", 32'(last_m), 32'd1);
    check_eq("tick3_check", 32'(ifc.Check), 32'd5);
    check_eq("tick3_idle", 32'(ifc.Data_Ready), 32'd1);

    // Abort a frame while its 5th bit is on the line.
    ifc.Data_In = 8'd13;
    ifc.Data_Valid = 1'b1;
    step();
    ifc.Data_Valid = 1'b0;
    repeat (4) step();
    check_eq("abort_midframe", 32'(ifc.Bit_Valid), 32'd1);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    check_eq("abort_valid", 32'(ifc.Bit_Valid), 32'd0);
    check_eq("abort_ready", 32'(ifc.Data_Ready), 32'd1);
    check_eq("abort_string", 32'(ifc.String), 32'd0);
    check_eq("abort_check", 32'(ifc.Check), 32'd0);
    send_frame(8'd7, 1, seq, last_m, valid_m, hold_err);
    check_eq("p7_seq", 32'(seq), 32'(11'b0000_0111_000));
    check_eq("p7_check", 32'(ifc.Check), 32'd0);
    check_eq("p7_last", 32'(last_m), 32'd1);

    // Back-to-back frames with Data_Valid held high and Data_In changing mid-frame.
    ifc.Data_In = 8'd13;
    ifc.Data_Valid = 1'b1;
    Tick = 1'b1;
    step();
    ifc.Data_In = 8'hFF;
    for (int i = 0; i < 23; i++) begin
      str_obs[22-i] = ifc.String;
      val_obs[22-i] = ifc.Bit_Valid;
      rdy_obs[22-i] = ifc.Data_Ready;
      if (i == 7)  check_eq("b2b_check_pre", 32'(ifc.Check), 32'd0);
      if (i == 8)  check_eq("b2b_check_f1", 32'(ifc.Check), 32'd1);
      if (i == 19) check_eq("b2b_check_hold", 32'(ifc.Check), 32'd1);
      if (i == 20) check_eq("b2b_check_f2", 32'(ifc.Check), 32'd4);
      if (i == 12) ifc.Data_Valid = 1'b0;
      step();
    end
    check_eq("b2b_string", 32'(str_obs), 32'({11'b0000_1101_001, 1'b0, 11'b1111_1111_100}));
    check_eq("b2b_valid", 32'(val_obs), 32'({11'h7FF, 1'b0, 11'h7FF}));
    check_eq("b2b_ready", 32'(rdy_obs), 32'({11'h000, 1'b1, 11'h000}));
    check_eq("b2b_end_idle", 32'(ifc.Data_Ready), 32'd1);

    // Every payload: frame value divisible by 7 and Check matches the model.
    for (int p = 0; p < 256; p++) begin
      c_exp = 3'((7 - (p % 7)) % 7);
      frame_exp = {8'(p), c_exp};
      send_frame(8'(p), 1, seq, last_m, valid_m, hold_err);
      check_eq("all_seq", 32'(seq), 32'(frame_exp));
      check_eq("all_mod7", 32'(seq) % 32'd7, 32'd0);
      check_eq("all_check", 32'(ifc.Check), 32'(c_exp));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod7_frame_serializer.md
# mod7_frame_serializer

Transmit end of the serial divisibility-by-7 link. Accepts a parallel payload word over a valid/ready handshake and shifts it out MSB-first on a single-bit `String` line. It then appends a 3-bit check field so that the whole serialized frame, read as a binary number, is divisible by 7. The downstream divisibility checker sees remainder 0, and `Divisible` asserted, on the frame's last bit.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload width in bits, minimum 3.

Ports:
- `Clock`, input, 1 bit: rising-edge clock.
- `Reset`, input, 1 bit: reset, synchronous, active-low.
- `Tick`, input, 1 bit: bit-rate enable. Serializer state advances only on cycles with `Tick`=1.
- `Data_In`, input, `DATA_WIDTH` bits: payload, sampled on the accept cycle.
- `Data_Valid`, input, 1 bit: payload offered.
- `Data_Ready`, output, 1 bit: serializer can accept a payload this cycle.
- `String`, output, 1 bit: serial bit currently presented, MSB first.
- `Bit_Valid`, output, 1 bit: `String` carries a frame bit.
- `Bit_Last`, output, 1 bit: current bit is the final check bit.
- `Check`, output, 3 bits: check value of the current or most recent frame.

## Operation
- Frame length is `DATA_WIDTH`+3 bits: the payload followed by check c, MSB first.
- c = (7 − (payload mod 7)) mod 7. This holds because payload·8 ≡ payload (mod 7). c is always in 0..6, so it never equals 3'b111.
- Remainder is computed serially as payload bits leave: rem ← (2·rem + bit) mod 7. The intermediate value needs 4 bits; the stored remainder is 3 bits. No divider is used.
- The FSM has three states: IDLE, DATA and CHECK.
  - IDLE: `Data_Ready`=1, `Bit_Valid`=0, `String`=0. When `Data_Valid`=1, the shift register loads `Data_In`, rem←0, bit count←`DATA_WIDTH`−1, and the FSM goes to DATA. `Tick` is not required to accept.
  - DATA: `String` = shift-register MSB and `Bit_Valid`=1. On `Tick`, rem is updated with that bit and the register shifts left. When the count reaches 0 on a `Tick`, the check field loads (7−rem_next) mod 7 into the 3-bit shift register and into `Check`, count←2, and the FSM goes to CHECK.
  - CHECK: `String` = check MSB and `Bit_Valid`=1. `Bit_Last`=1 when count=0. On `Tick` with count=0, the FSM goes to IDLE.
- `Data_Ready` is 1 only in IDLE. The block does not accept a payload while the final bit is leaving.
- `Tick`=0 freezes the state, count, shift registers, rem and all outputs.
- `Check` holds its value until the next frame's check is computed.

## Timing
- Reset, when `Reset`=0 at a rising edge, overrides everything, including mid-frame. The FSM goes to IDLE, with `String`=0, `Bit_Valid`=0, `Bit_Last`=0, `Data_Ready`=1, `Check`=0, rem=0 and count=0. A partial frame is abandoned and never resumed.
- Accept edge is the edge where IDLE and `Data_Valid`=1. The first payload bit appears on `String` the cycle after that edge.
- Each bit is held from one `Tick` edge to the next. With `Tick` tied high, a frame takes exactly `DATA_WIDTH`+3 cycles.
- After the edge that consumes the last bit, the block is in IDLE for at least one cycle. Back-to-back frames with `Tick`=1 are separated by exactly one idle cycle.
- The check bits follow the last payload bit with no gap. The first check bit is valid the cycle after the last payload bit's `Tick` edge.
- `Data_In` and `Data_Valid` are ignored outside IDLE.

## Structure
- A shared package or include holds `MODULUS`=7, `CHECK_WIDTH`=3, the FSM state encodings (IDLE, DATA, CHECK) and a mod-7 step function: (rem, bit) → (2·rem+bit) mod 7. The checker uses the same step function.
- One sub-module, `mod7_step`, is combinational: 3-bit rem and a 1-bit input produce the 3-bit next remainder. It is instantiated once here and is reusable by the checker.
- The shift register, counter and FSM live in the top module.

## Test plan
- `DATA_WIDTH`=8, `Tick`=1, payload 8'd13:
  - Required: `String` sequence 0000_1101_001, `Check`=1, `Bit_Last` on bit 11.
  - When looped into the checker, its remainder is 0 and `Divisible`=1 on the last bit (105 = 7·15).
- Payload 8'hFF: sequence 1111_1111_100, `Check`=4 (2044 = 7·292). Payload 8'd0: eleven 0 bits, `Check`=0.
- `Tick` pulsed every 3rd cycle, payload 8'd100 (100 mod 7 = 2, c=5): each bit is held 3 cycles, the sequence is 0110_0100_101, and no bit is dropped or duplicated.
- `Reset`=0 asserted on the 5th bit of a frame: the next cycle shows IDLE, `Bit_Valid`=0 and `Data_Ready`=1. A new payload 8'd7 (c=0) then yields the full frame 0000_0111_000.
- `Data_Valid` held high with two queued payloads, 8'd13 then 8'hFF: exactly one idle cycle between frames. `Data_Valid` pulses during a frame are ignored and `Check` changes only at each frame's check load.
- Randomized check over all 256 payloads: the frame value mod 7 = 0, and `Check` = (7 − p mod 7) mod 7.
